ultrasonido_ctrl: RTL and testbench
===================================

Name: ultrasonido_ctrl

Overview:
Controller for an HC-SR04-style ultrasonic range sensor. It emits a periodic trigger pulse and measures the width of the returned echo pulse. It converts that width to centimetres and flags completion with a one-cycle done pulse. It sits between the sensor pins and game logic that consumes the distance value.

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
CYCLES_PER_CM, 2900, echo-high clk cycles per centimetre (58 us at 50 MHz)
TIMEOUT_CYCLES, 1900000, max cycles from trigger end to echo fall before abort (38 ms)
PERIOD_CYCLES, 3000000, trigger-start to trigger-start period (60 ms); must exceed TRIG_CYCLES+TIMEOUT_CYCLES+4
DIST_WIDTH, 9, width of distance output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
echo  in  1  sensor echo pin, asynchronous to clk
trigger  out  1  sensor trigger pin, registered
done  out  1  one-cycle pulse: new measurement result valid
distance  out  DIST_WIDTH  last measured distance in cm, held between measurements
timeout  out  1  high when last measurement aborted (no/too-long echo), held with distance

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset=0 resets). All outputs are registered.
- Reset values:
  - trigger=0, done=0, distance=0, timeout=0.
  - State IDLE; all counters 0; echo synchroniser flops 0.
- echo passes through a 2-flop synchroniser (echo_s) before use; echo_s lags echo by 2 cycles. Edges are detected on echo_s versus its previous value.
- A period counter runs from each TRIG entry and wraps at PERIOD_CYCLES-1.
- States:
  - IDLE: entered from reset; next cycle goes to TRIG.
  - TRIG: trigger=1 for exactly TRIG_CYCLES cycles, then WAIT_LOW. The trigger rises the cycle after TRIG entry.
  - WAIT_LOW: waits for echo_s=0, so a stale high echo is never measured. Then WAIT_ECHO.
  - WAIT_ECHO: on echo_s rising edge, clear the cm counter and prescaler, then go to MEASURE.
  - MEASURE: each cycle echo_s=1, prescaler increments. When the prescaler reaches CYCLES_PER_CM-1 it wraps to 0 and the cm counter increments, saturating at 2^DIST_WIDTH-1. On echo_s falling edge go to RESULT.
  - RESULT (1 cycle): distance<=cm counter, timeout<=0, done=1. Then HOLDOFF.
  - HOLDOFF: waits until the period counter wraps, then TRIG.
- Timeout:
  - A timeout counter starts at 0 on leaving TRIG and runs through WAIT_LOW, WAIT_ECHO and MEASURE.
  - Reaching TIMEOUT_CYCLES forces ABORT (1 cycle): distance<=all ones, timeout<=1, done=1. Then HOLDOFF.
  - If timeout and echo fall coincide in the same cycle, timeout wins.
- done is high only in the RESULT or ABORT cycle, exactly 1 cycle per measurement.
- Outputs during a measurement: distance and timeout change only together with done.
- Partial pulses: echo pulses shorter than CYCLES_PER_CM give distance 0. A partial prescaler count is discarded (truncation).
- Echo glitches during TRIG or HOLDOFF are ignored.
- reset asserted mid-operation returns immediately to the reset values. The next measurement restarts from IDLE after release.

Test Plan:
(Bench parameters: TRIG_CYCLES=3, CYCLES_PER_CM=4, TIMEOUT_CYCLES=100, PERIOD_CYCLES=200, DIST_WIDTH=9.)
1. Reset: hold reset=0 with echo toggling -> trigger=0, done=0, distance=0, timeout=0 throughout.
2. Trigger timing: release reset, echo=0 -> trigger high exactly 3 consecutive cycles starting 2 cycles after release; rises again exactly 200 cycles later.
3. Nominal: echo high 20 cycles after trigger falls -> done pulses once, 1 cycle, about 3 cycles after echo falls; distance=5, timeout=0.
4. Truncation/short: echo high 23 cycles -> distance=5; echo high 2 cycles -> distance=0, done still pulses.
5. No echo: echo stays 0 -> done pulse 100 cycles after trigger falls, distance=511, timeout=1; next measurement with 8-cycle echo -> distance=2, timeout=0.
6. Stale echo/reset: echo held 1 through trigger, then low, then a 12-cycle pulse -> distance=3. Separately, assert reset during MEASURE -> outputs 0 and no done pulse; a fresh trigger follows release.

Source files
------------

// File: rtl/ultrasonido_ctrl.sv
// HC-SR04-style ultrasonic ranger controller.
// Fires a periodic trigger pulse, times the returned echo pulse and reports
// the width in centimetres with a one-cycle done strobe. A missing or
// over-long echo is reported as an all-ones distance with timeout set.
module ultrasonido_ctrl #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int DIST_WIDTH     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  echo,
  output logic                  trigger,
  output logic                  done,
  output logic [DIST_WIDTH-1:0] distance,
  output logic                  timeout
);

  localparam int TRW = $clog2(TRIG_CYCLES + 1);
  localparam int PSW = $clog2(CYCLES_PER_CM + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int PRW = $clog2(PERIOD_CYCLES + 1);

  localparam logic [TRW-1:0] TRIG_LAST   = TRW'(TRIG_CYCLES - 1);
  localparam logic [PSW-1:0] PRESC_LAST  = PSW'(CYCLES_PER_CM - 1);
  localparam logic [TOW-1:0] TO_LIMIT    = TOW'(TIMEOUT_CYCLES);
  localparam logic [PRW-1:0] PERIOD_LAST = PRW'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_LOW, WAIT_ECHO, MEASURE, RESULT, ABORT, HOLDOFF
  } state_t;

  state_t state, next_state;

  logic                  echo_p0, echo_s, echo_s_p1;
  logic                  echo_rise, echo_fall;
  logic [TRW-1:0]        trig_cnt;
  logic [PRW-1:0]        period_cnt;
  logic [TOW-1:0]        to_cnt;
  logic [PSW-1:0]        presc;
  logic [DIST_WIDTH-1:0] cm_cnt;
  logic                  to_hit, period_last, to_active;

  // Prescaler advance: wraps once a full centimetre of echo has elapsed.
  function automatic logic [PSW-1:0] presc_step(input logic [PSW-1:0] p);
    return (p == PRESC_LAST) ? '0 : p + 1'b1;
  endfunction

  // Centimetre advance on prescaler wrap, saturating at all ones.
  function automatic logic [DIST_WIDTH-1:0] cm_sat_step(input logic [DIST_WIDTH-1:0] c,
                                                        input logic [PSW-1:0]        p);
    if (p == PRESC_LAST && c != '1) return c + 1'b1;
    return c;
  endfunction

  assign echo_rise   = echo_s & ~echo_s_p1;
  assign echo_fall   = ~echo_s & echo_s_p1;
  assign to_hit      = (to_cnt == TO_LIMIT);
  assign period_last = (period_cnt == PERIOD_LAST);
  assign to_active   = (state == WAIT_LOW) || (state == WAIT_ECHO) || (state == MEASURE);

  // Two-flop synchroniser for the asynchronous echo pin plus an edge-detect delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_p0   <= 1'b0;
      echo_s    <= 1'b0;
      echo_s_p1 <= 1'b0;
    end else begin
      echo_p0   <= echo;
      echo_s    <= echo_p0;
      echo_s_p1 <= echo_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; an expiring timeout beats a coincident echo edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      next_state = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) next_state = WAIT_LOW;
      WAIT_LOW:  if (to_hit) next_state = ABORT; else if (!echo_s) next_state = WAIT_ECHO;
      WAIT_ECHO: if (to_hit) next_state = ABORT; else if (echo_rise) next_state = MEASURE;
      MEASURE:   if (to_hit) next_state = ABORT; else if (echo_fall) next_state = RESULT;
      RESULT:    next_state = HOLDOFF;
      ABORT:     next_state = HOLDOFF;
      HOLDOFF:   if (period_last) next_state = TRIG;
      default:   next_state = IDLE;
    endcase
  end

  // Trigger length, measurement period and timeout counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_cnt   <= '0;
      period_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      trig_cnt <= (state == TRIG) ? trig_cnt + 1'b1 : '0;
      if ((next_state == TRIG && state != TRIG) || period_last) period_cnt <= '0;
      else                                                      period_cnt <= period_cnt + 1'b1;
      if (state == TRIG)  to_cnt <= '0;
      else if (to_active) to_cnt <= to_cnt + 1'b1;
    end
  end

  // Echo width measurement; the rising-edge cycle already has echo_s high, so
  // it is counted as the first cycle starting from a cleared count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      cm_cnt <= '0;
    end else if (state == WAIT_ECHO && echo_rise) begin
      presc  <= presc_step('0);
      cm_cnt <= cm_sat_step('0, '0);
    end else if (state == MEASURE && echo_s) begin
      presc  <= presc_step(presc);
      cm_cnt <= cm_sat_step(cm_cnt, presc);
    end
  end

  // Registered outputs; done/distance/timeout update on entry to RESULT or ABORT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trigger  <= 1'b0;
      done     <= 1'b0;
      distance <= '0;
      timeout  <= 1'b0;
    end else begin
      trigger <= (state == TRIG);
      done    <= (next_state == RESULT) || (next_state == ABORT);
      if (next_state == RESULT) begin
        distance <= cm_cnt;
        timeout  <= 1'b0;
      end else if (next_state == ABORT) begin
        distance <= '1;
        timeout  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Directed bench for ultrasonido_ctrl with short timing parameters.
// Time t counts rising edges since reset release (t=1 is the first edge).
module tb_ultrasonido_ctrl;

  localparam int DW = 9;

  logic          clk;
  logic          reset;
  logic          echo;
  logic          trigger;
  logic          done;
  logic [DW-1:0] distance;
  logic          timeout;

  int t;
  int total;
  int bad;

  ultrasonido_ctrl #(
    .TRIG_CYCLES   (3),
    .CYCLES_PER_CM (4),
    .TIMEOUT_CYCLES(100),
    .PERIOD_CYCLES (200),
    .DIST_WIDTH    (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .echo    (echo),
    .trigger (trigger),
    .done    (done),
    .distance(distance),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Echo of n cycles starting just after edge 'base'; n=0 means no echo.
  task automatic measure(input string tag, input int base, input int n,
                         input int exp_dist, input int exp_t);
    while (t < base) tick();
    if (n > 0) begin
      echo = 1'b1;
      repeat (n) tick();
      echo = 1'b0;
    end
    wait_done(300);
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_done_time"}, t, exp_t);
    chk({tag, "_distance"}, distance, exp_dist);
    chk({tag, "_timeout"}, timeout, (n == 0) ? 1 : 0);
    tick();
    chk({tag, "_done_width"}, {done, timeout, distance}, {1'b0, (n == 0), exp_dist[DW-1:0]});
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    t     = 0;
    reset = 1'b0;
    echo  = 1'b0;

    // Reset held with echo toggling
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      echo = ~echo;
      @(posedge clk);
      #1;
      chk("reset_outputs", {trigger, done, timeout, distance}, 0);
    end
    echo  = 1'b0;
    reset = 1'b1;
    t     = 0;

    // Trigger high on edges 2..4
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("trig_shape", trigger, (i >= 2 && i <= 4) ? 1 : 0);
    end

    // No echo in the first period: abort 100 cycles after trigger fall (edge 5)
    wait_done(300);
    chk("abort0_done_seen", done, 1);
    chk("abort0_done_time", t, 105);
    chk("abort0_distance", distance, 511);
    chk("abort0_timeout", timeout, 1);
    tick();
    chk("abort0_done_width", done, 0);

    // Next trigger rises exactly one period later
    n = 0;
    while (trigger !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("trig_period", t, 202);

    // Measurements, each starting at trigger fall of its period
    measure("nominal20", 205, 20, 5, 228);
    measure("trunc23", 405, 23, 5, 431);
    measure("short2", 605, 2, 0, 610);
    measure("noecho", 805, 0, 511, 905);
    measure("echo8", 1005, 8, 2, 1016);

    // Stale echo held high through the trigger, then a 12-cycle pulse
    while (t < 1195) tick();
    echo = 1'b1;
    while (t < 1210) tick();
    echo = 1'b0;
    while (t < 1220) tick();
    echo = 1'b1;
    repeat (12) tick();
    echo = 1'b0;
    wait_done(300);
    chk("stale_done_seen", done, 1);
    chk("stale_done_time", t, 1235);
    chk("stale_distance", distance, 3);
    chk("stale_timeout", timeout, 0);

    // Reset asserted while measuring
    while (t < 1405) tick();
    echo = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
    #1;
    chk("midreset_outputs", {trigger, done, timeout, distance}, 0);
    echo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midreset_quiet", {trigger, done, timeout, distance}, 0);
    end
    reset = 1'b1;
    t     = 0;
    tick();
    chk("restart_trig_t1", trigger, 0);
    tick();
    chk("restart_trig_t2", trigger, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
